// File: rtl/planificador_vc_pkg.sv
// Shared enrutamiento definitions: scheduler state encoding and default bus geometry.
package planificador_vc_pkg;

    localparam int DATA_W_DEF   = 6;
    localparam int DEST_BIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVO    = 2'd1,
        BLOQUEADO = 2'd2
    } estado_t;

endpackage

// File: rtl/planificador_elegibilidad.sv
// Combinational eligibility/conflict detector for the two VCs; no state, zero latency.
module planificador_elegibilidad (
    input  logic vc0_empty,
    input  logic vc1_empty,
    input  logic dest0,
    input  logic dest1,
    input  logic d0_pause,
    input  logic d1_pause,
    output logic elig0,
    output logic elig1,
    output logic conflicto
);

    logic pause0;
    logic pause1;

    // Each VC only cares about the pause flag of the destination its head targets.
    assign pause0    = dest0 ? d1_pause : d0_pause;
    assign pause1    = dest1 ? d1_pause : d0_pause;
    assign elig0     = !vc0_empty && !pause0;
    assign elig1     = !vc1_empty && !pause1;
    assign conflicto = elig0 && elig1 && (dest0 == dest1);

endmodule

// File: rtl/planificador_vc.sv
// Two-VC to two-destination scheduler: combinational pops, one-cycle registered pushes,
// weighted VC0 priority on conflicts with a saturating starvation counter for VC1.
module planificador_vc
    import planificador_vc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF,
    parameter int WEIGHT   = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] VC0_head,
    input  logic [DATA_W-1:0] VC1_head,
    input  logic              VC0_empty,
    input  logic              VC1_empty,
    input  logic              D0_pause,
    input  logic              D1_pause,
    output logic              VC0_pop,
    output logic              VC1_pop,
    output logic              D0_push,
    output logic              D1_push,
    output logic [DATA_W-1:0] D0_out,
    output logic [DATA_W-1:0] D1_out,
    output logic [1:0]        estado
);

    localparam logic [3:0] WEIGHT_C = 4'(WEIGHT);

    logic       dest0;
    logic       dest1;
    logic       elig0;
    logic       elig1;
    logic       conflicto;
    logic [3:0] starve_cnt;
    estado_t    state;

    assign dest0  = VC0_head[DEST_BIT];
    assign dest1  = VC1_head[DEST_BIT];
    assign estado = state;

    planificador_elegibilidad u_elig (
        .vc0_empty (VC0_empty),
        .vc1_empty (VC1_empty),
        .dest0     (dest0),
        .dest1     (dest1),
        .d0_pause  (D0_pause),
        .d1_pause  (D1_pause),
        .elig0     (elig0),
        .elig1     (elig1),
        .conflicto (conflicto)
    );

    always_comb begin
        VC0_pop = 1'b0;
        VC1_pop = 1'b0;
        if (reset_L) begin
            if (conflicto) begin
                VC0_pop = (starve_cnt < WEIGHT_C);
                VC1_pop = !(starve_cnt < WEIGHT_C);
            end else begin
                VC0_pop = elig0;
                VC1_pop = elig1;
            end
        end
    end

    // Dual issue only happens with distinct destinations, so at most one VC feeds each Dk.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            D0_push    <= 1'b0;
            D1_push    <= 1'b0;
            D0_out     <= '0;
            D1_out     <= '0;
            starve_cnt <= '0;
            state      <= IDLE;
        end else begin
            D0_push <= (VC0_pop && !dest0) || (VC1_pop && !dest1);
            D1_push <= (VC0_pop && dest0) || (VC1_pop && dest1);

            if (VC0_pop && !dest0)      D0_out <= VC0_head;
            else if (VC1_pop && !dest1) D0_out <= VC1_head;

            if (VC0_pop && dest0)       D1_out <= VC0_head;
            else if (VC1_pop && dest1)  D1_out <= VC1_head;

            if (VC1_pop)
                starve_cnt <= '0;
            else if (conflicto && VC0_pop && starve_cnt < WEIGHT_C)
                starve_cnt <= starve_cnt + 4'd1;

            if (VC0_empty && VC1_empty)
                state <= IDLE;
            else if (VC0_pop || VC1_pop)
                state <= ACTIVO;
            else
                state <= BLOQUEADO;
        end
    end

endmodule

// File: doc/planificador_vc.md
PLANIFICADOR_VC -- requirements
Module: planificador_vc

Interface
REQ-001 SHALL have parameter DATA_W, default 6, width of VC head words and D outputs.
REQ-002 SHALL have parameter DEST_BIT, default 4, index of the head-word bit selecting the destination (0 = D0, 1 = D1).
REQ-003 SHALL have parameter WEIGHT, default 3, maximum consecutive VC0 wins of a conflict while VC1 waits (range 1..15).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port reset_L, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have ports VC0_head and VC1_head, input, DATA_W each, show-ahead FIFO head word, valid while the matching empty flag is 0.
REQ-007 SHALL have ports VC0_empty and VC1_empty, input, 1 each, source FIFO empty flags.
REQ-008 SHALL have ports D0_pause and D1_pause, input, 1 each, destination almost-full flags (at least one free slot remaining).
REQ-009 SHALL have ports VC0_pop and VC1_pop, output, 1 each, combinational pop strobes to the source FIFOs.
REQ-010 SHALL have ports D0_push and D1_push, output, 1 each, registered push strobes to the destination FIFOs.
REQ-011 SHALL have ports D0_out and D1_out, output, DATA_W each, registered data to the destination FIFOs.
REQ-012 SHALL have port estado, output, 2, registered FSM state: 0 IDLE, 1 ACTIVO, 2 BLOQUEADO.

Function
REQ-013 SHALL define dest(x) = VCx_head[DEST_BIT], and SHALL treat VCx as eligible when VCx_empty is 0 and D[dest(x)]_pause is 0.
REQ-014 SHALL pop both VCs in the same cycle when both are eligible and dest(0) differs from dest(1) (dual issue).
REQ-015 On a conflict (both eligible, same dest), SHALL pop VC0 when starve_cnt is less than WEIGHT, otherwise SHALL pop VC1.
REQ-016 SHALL increment starve_cnt on each conflict won by VC0.
REQ-017 SHALL clear starve_cnt on a conflict won by VC1 and on any cycle where VC1 is popped.
REQ-018 SHALL hold starve_cnt in all other cycles.
REQ-019 SHALL pop a single eligible VC whenever the other VC is not eligible.
REQ-020 SHALL keep VCx_pop at 0 whenever VCx_empty is 1, even if the head word carries stale data.
REQ-021 SHALL give a fixed latency of one cycle: a pop of VCx in cycle N produces D[dest(x)]_push = 1 in cycle N+1, with D[dest(x)]_out equal to the VCx_head value sampled in cycle N.
REQ-022 SHALL hold Dk_out at its last value and drive Dk_push to 0 in any cycle without a push to Dk.
REQ-023 SHALL sample pause in the pop cycle only; a push already issued completes even if pause rises in cycle N+1, relying on the almost-full margin.
REQ-024 SHALL use FSM next-state rules: IDLE when both VCs are empty; ACTIVO when at least one pop occurs; BLOQUEADO when a non-empty VC exists but none is eligible.
REQ-025 SHALL register estado one cycle after its conditions are evaluated.
REQ-026 SHALL saturate starve_cnt at WEIGHT and never wrap.

Reset
REQ-027 While reset_L is 0 at a clock edge, SHALL drive D0_push and D1_push to 0, D0_out and D1_out to 0, starve_cnt to 0, and estado to IDLE.
REQ-028 SHALL force VC0_pop and VC1_pop to 0 combinationally while reset_L is 0.
REQ-029 SHALL drop any push pending from the cycle before reset, so that no Dk_push occurs in the cycle after reset is asserted mid-transfer.

Structure
REQ-030 SHALL place the estado encodings (IDLE, ACTIVO, BLOQUEADO) and the DATA_W and DEST_BIT defaults in the shared include package used by the enrutamiento blocks.
REQ-031 SHALL contain exactly one sub-module, planificador_elegibilidad: a combinational eligibility and conflict detector producing elig0, elig1 and conflicto.
REQ-032 SHALL keep the arbitration, starvation counter, FSM and output registers in the top module.

Verification
REQ-033 Dual issue: VC0_head = 6'h05 (D0), VC1_head = 6'h12 (D1), both non-empty, no pause -> both pops in cycle N; next cycle D0_push = 1 with D0_out = 05 and D1_push = 1 with D1_out = 12.
REQ-034 Starvation: both heads target D1, both FIFOs stay non-empty, WEIGHT = 3 -> pop sequence VC0, VC0, VC0, VC1, VC0, VC0, VC0, VC1.
REQ-035 Pause: D0_pause = 1, VC0 head targets D0, VC1 empty -> no pops, estado = BLOQUEADO one cycle later; on D0_pause falling, VC0_pop = 1 in the same cycle.
REQ-036 Empty guard: VC0_empty = 1 with VC0_head = 6'h3F -> VC0_pop = 0 and no D push.
REQ-037 Reset mid-transfer: pop in cycle N, reset_L = 0 sampled at the end of cycle N -> D pushes and outputs are 0 in cycle N+1, starve_cnt = 0, estado = IDLE.
